// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit ALU: operand fetch, execute, flag save, writeback.
// Latency 5+ cycles per opcode (plus memory waits); i_Enable low stalls everything, new opcodes taken only in IDLE.
module alu_sequencer #(
    parameter int MEM_INDEX = 6,
    parameter int A_INDEX   = 7
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Enable,
    input  logic       i_Op_Valid,
    input  logic       i_CB,
    input  logic [7:0] i_Op,
    output logic       o_Op_Ready,
    output logic       o_Done,
    output logic       o_Illegal,
    output logic [2:0] o_Reg_Sel,
    output logic       o_Reg_Read,
    output logic       o_Reg_Write,
    input  logic [7:0] i_Reg_Data,
    output logic       o_Mem_Req,
    output logic       o_Mem_Wr,
    output logic       o_Mem_Addr_Sel,
    output logic       o_PC_Inc,
    input  logic       i_Mem_Ack,
    input  logic [7:0] i_Mem_Data,
    output logic [1:0] o_ALU_Read,
    output logic [1:0] o_ALU_Write,
    output logic [5:0] o_Function_Control,
    output logic [7:0] o_Opcode,
    output logic [7:0] o_Parameter,
    output logic       o_Save_Flags,
    input  logic [7:0] i_ALU_Reg_Data,
    input  logic [7:0] i_ALU_Result,
    output logic [7:0] o_Wr_Data
);

    localparam logic [2:0] MEM_IDX = 3'(MEM_INDEX);
    localparam logic [2:0] A_IDX   = 3'(A_INDEX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPERAND,
        S_MEM_RD,
        S_EXEC,
        S_WRITEBACK,
        S_MEM_WR,
        S_DONE,
        S_ILLEGAL
    } state_t;

    typedef struct packed {
        logic       imm;
        logic [2:0] src;
        logic [2:0] dst;
        logic       wb;
        logic       save;
        logic [5:0] fc;
    } dec_t;

    // Returns legality; the decoded control word is latched on accept so the opcode is decoded once.
    function automatic logic decode(input logic cb, input logic [7:0] op, output dec_t d);
        logic legal;
        d     = '0;
        legal = 1'b1;
        if (cb) begin
            d.fc   = 6'b001000;
            d.src  = op[2:0];
            d.dst  = op[2:0];
            d.wb   = (op[7:6] != 2'b01);
            d.save = ~op[7];
        end else if (op[7:6] == 2'b10 || (op[7:6] == 2'b11 && op[2:0] == 3'b110)) begin
            d.fc   = 6'b000001;
            d.imm  = op[6];
            d.src  = op[2:0];
            d.dst  = A_IDX;
            d.wb   = (op[5:3] != 3'd7);
            d.save = 1'b1;
        end else if (op[7:6] == 2'b00 && op[2:1] == 2'b10) begin
            d.fc   = {3'b000, op[0], 1'b1, 1'b0};
            d.src  = op[5:3];
            d.dst  = op[5:3];
            d.wb   = 1'b1;
            d.save = 1'b1;
        end else if (op[7:5] == 3'b000 && op[2:0] == 3'b111) begin
            d.fc   = 6'b011000;
            d.src  = A_IDX;
            d.dst  = A_IDX;
            d.wb   = 1'b1;
            d.save = 1'b1;
        end else if (op[7:5] == 3'b001 && op[2:0] == 3'b111) begin
            // 0x27/0x2F rewrite A, 0x37/0x3F only touch flags
            d.fc   = 6'b100000;
            d.src  = A_IDX;
            d.dst  = A_IDX;
            d.wb   = ~op[4];
            d.save = 1'b1;
        end else begin
            legal = 1'b0;
        end
        return legal;
    endfunction

    state_t     state_q, state_d;
    dec_t       dec_q, dec_d, dec_in;
    logic       legal_in;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] param_q, param_d;
    logic [7:0] result_q, result_d;

    assign o_Op_Ready  = i_Rst | (state_q == S_IDLE);
    assign o_Opcode    = opcode_q;
    assign o_Parameter = param_q;
    assign o_Wr_Data   = result_q;

    always_comb begin
        state_d            = state_q;
        dec_d              = dec_q;
        opcode_d           = opcode_q;
        param_d            = param_q;
        result_d           = result_q;
        o_Done             = 1'b0;
        o_Illegal          = 1'b0;
        o_Reg_Sel          = 3'd0;
        o_Reg_Read         = 1'b0;
        o_Reg_Write        = 1'b0;
        o_Mem_Req          = 1'b0;
        o_Mem_Wr           = 1'b0;
        o_Mem_Addr_Sel     = 1'b0;
        o_PC_Inc           = 1'b0;
        o_ALU_Read         = 2'b00;
        o_ALU_Write        = 2'b00;
        o_Function_Control = 6'd0;
        o_Save_Flags       = 1'b0;
        legal_in           = decode(i_CB, i_Op, dec_in);

        // Reset kills every strobe in the same cycle, including an outstanding memory request.
        if (i_Enable && !i_Rst) begin
            case (state_q)
                S_IDLE: begin
                    if (i_Op_Valid) begin
                        opcode_d = i_Op;
                        dec_d    = dec_in;
                        if (!legal_in) begin
                            state_d = S_ILLEGAL;
                        end else if (dec_in.imm || dec_in.src == MEM_IDX) begin
                            state_d = S_MEM_RD;
                        end else begin
                            state_d = S_OPERAND;
                        end
                    end
                end
                S_OPERAND: begin
                    if (dec_q.src == A_IDX) begin
                        o_ALU_Read = 2'b01;
                        param_d    = i_ALU_Reg_Data;
                    end else begin
                        o_Reg_Read = 1'b1;
                        o_Reg_Sel  = dec_q.src;
                        param_d    = i_Reg_Data;
                    end
                    state_d = S_EXEC;
                end
                S_MEM_RD: begin
                    o_Mem_Req      = 1'b1;
                    o_Mem_Addr_Sel = dec_q.imm;
                    if (i_Mem_Ack) begin
                        param_d = i_Mem_Data;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    o_Function_Control = dec_q.fc;
                    o_Save_Flags       = dec_q.save;
                    o_PC_Inc           = dec_q.imm;
                    result_d           = i_ALU_Result;
                    state_d            = (dec_q.wb && dec_q.dst == MEM_IDX) ? S_MEM_WR : S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (dec_q.wb) begin
                        if (dec_q.dst == A_IDX) begin
                            o_ALU_Write = 2'b01;
                        end else begin
                            o_Reg_Write = 1'b1;
                            o_Reg_Sel   = dec_q.dst;
                        end
                    end
                    state_d = S_DONE;
                end
                S_MEM_WR: begin
                    o_Mem_Req = 1'b1;
                    o_Mem_Wr  = 1'b1;
                    if (i_Mem_Ack) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    o_Done  = 1'b1;
                    state_d = S_IDLE;
                end
                S_ILLEGAL: begin
                    o_Illegal = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= S_IDLE;
            dec_q    <= '0;
            opcode_q <= 8'd0;
            param_q  <= 8'd0;
            result_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            dec_q    <= dec_d;
            opcode_q <= opcode_d;
            param_q  <= param_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: transaction-level model predicts every cycle's outputs, random and directed opcodes.
module tb_alu_sequencer;

    logic       i_Clk = 1'b0;
    logic       i_Rst, i_Enable, i_Op_Valid, i_CB, i_Mem_Ack;
    logic [7:0] i_Op, i_Reg_Data, i_Mem_Data, i_ALU_Reg_Data, i_ALU_Result;
    logic       o_Op_Ready, o_Done, o_Illegal, o_Reg_Read, o_Reg_Write;
    logic       o_Mem_Req, o_Mem_Wr, o_Mem_Addr_Sel, o_PC_Inc, o_Save_Flags;
    logic [2:0] o_Reg_Sel;
    logic [1:0] o_ALU_Read, o_ALU_Write;
    logic [5:0] o_Function_Control;
    logic [7:0] o_Opcode, o_Parameter, o_Wr_Data;

    always #5 i_Clk = ~i_Clk;

    alu_sequencer #(.MEM_INDEX(6), .A_INDEX(7)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable), .i_Op_Valid(i_Op_Valid),
        .i_CB(i_CB), .i_Op(i_Op), .o_Op_Ready(o_Op_Ready), .o_Done(o_Done),
        .o_Illegal(o_Illegal), .o_Reg_Sel(o_Reg_Sel), .o_Reg_Read(o_Reg_Read),
        .o_Reg_Write(o_Reg_Write), .i_Reg_Data(i_Reg_Data), .o_Mem_Req(o_Mem_Req),
        .o_Mem_Wr(o_Mem_Wr), .o_Mem_Addr_Sel(o_Mem_Addr_Sel), .o_PC_Inc(o_PC_Inc),
        .i_Mem_Ack(i_Mem_Ack), .i_Mem_Data(i_Mem_Data), .o_ALU_Read(o_ALU_Read),
        .o_ALU_Write(o_ALU_Write), .o_Function_Control(o_Function_Control),
        .o_Opcode(o_Opcode), .o_Parameter(o_Parameter), .o_Save_Flags(o_Save_Flags),
        .i_ALU_Reg_Data(i_ALU_Reg_Data), .i_ALU_Result(i_ALU_Result), .o_Wr_Data(o_Wr_Data)
    );

    typedef struct packed {
        logic       op_ready, done, illegal, reg_read, reg_write;
        logic [2:0] reg_sel;
        logic       mem_req, mem_wr, addr_sel, pc_inc;
        logic [1:0] alu_read, alu_write;
        logic [5:0] fc;
        logic       save;
        logic [7:0] opcode, prm, wr_data;
        logic       k_sel, k_mem, k_wr;
    } out_t;

    typedef struct {
        bit         legal, imm, wb, save;
        int         src, dst;
        logic [5:0] fc;
    } mdec_t;

    int         n_vec = 0, n_bad = 0;
    out_t       exp_o;
    bit         exp_vld = 0;
    bit         stall_rnd = 0;
    logic [7:0] m_op = 8'd0, m_prm = 8'd0, m_res = 8'd0;
    logic [7:0] d_reg, d_areg, d_mem, d_res, cur_op;
    bit         cur_cb;
    int         cnt_req, cnt_pc, cnt_wstb, cnt_done, cnt_ill, cnt_fc, cnt_memwr, cnt_aluw;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, want, $time);
        end
    endtask

    always @(negedge i_Clk) begin
        if (exp_vld) begin
            chk("op_ready", 8'(o_Op_Ready), 8'(exp_o.op_ready));
            chk("done", 8'(o_Done), 8'(exp_o.done));
            chk("illegal", 8'(o_Illegal), 8'(exp_o.illegal));
            chk("reg_read", 8'(o_Reg_Read), 8'(exp_o.reg_read));
            chk("reg_write", 8'(o_Reg_Write), 8'(exp_o.reg_write));
            chk("mem_req", 8'(o_Mem_Req), 8'(exp_o.mem_req));
            chk("pc_inc", 8'(o_PC_Inc), 8'(exp_o.pc_inc));
            chk("alu_read", 8'(o_ALU_Read), 8'(exp_o.alu_read));
            chk("alu_write", 8'(o_ALU_Write), 8'(exp_o.alu_write));
            chk("func_ctrl", 8'(o_Function_Control), 8'(exp_o.fc));
            chk("save_flags", 8'(o_Save_Flags), 8'(exp_o.save));
            chk("opcode", o_Opcode, exp_o.opcode);
            chk("parameter", o_Parameter, exp_o.prm);
            if (exp_o.k_sel) chk("reg_sel", 8'(o_Reg_Sel), 8'(exp_o.reg_sel));
            if (exp_o.k_mem) begin
                chk("mem_wr", 8'(o_Mem_Wr), 8'(exp_o.mem_wr));
                chk("mem_addr_sel", 8'(o_Mem_Addr_Sel), 8'(exp_o.addr_sel));
            end
            if (exp_o.k_wr) chk("wr_data", o_Wr_Data, exp_o.wr_data);
        end
        if (o_Mem_Req) cnt_req++;
        if (o_PC_Inc) cnt_pc++;
        if (o_Reg_Write || o_ALU_Write != 2'b00 || (o_Mem_Req && o_Mem_Wr)) cnt_wstb++;
        if (o_Done) cnt_done++;
        if (o_Illegal) cnt_ill++;
        if (o_Function_Control != 6'd0) cnt_fc++;
        if (o_Mem_Req && o_Mem_Wr) cnt_memwr++;
        if (o_ALU_Write == 2'b01) cnt_aluw++;
    end

    task automatic clr_cnt();
        cnt_req = 0; cnt_pc = 0; cnt_wstb = 0; cnt_done = 0;
        cnt_ill = 0; cnt_fc = 0; cnt_memwr = 0; cnt_aluw = 0;
    endtask

    // Instruction-set rules: which unit, where the operand comes from, where the result goes.
    function automatic mdec_t model_decode(input bit cb, input int op);
        mdec_t m;
        m.legal = 1; m.imm = 0; m.wb = 1; m.save = 1; m.src = 7; m.dst = 7; m.fc = 6'd0;
        if (cb) begin
            m.fc = 6'b001000; m.src = op % 8; m.dst = op % 8;
            m.wb = (op / 64) != 1; m.save = (op < 128);
        end else if (op >= 128 && op < 192) begin
            m.fc = 6'b000001; m.src = op % 8; m.wb = ((op / 8) % 8) != 7;
        end else if (op >= 192 && op % 8 == 6) begin
            m.fc = 6'b000001; m.imm = 1; m.src = 6; m.wb = ((op / 8) % 8) != 7;
        end else if (op < 64 && (op % 8 == 4 || op % 8 == 5)) begin
            m.fc = (op % 8 == 4) ? 6'b000010 : 6'b000110;
            m.src = (op / 8) % 8; m.dst = m.src;
        end else if (op == 7 || op == 15 || op == 23 || op == 31) begin
            m.fc = 6'b011000;
        end else if (op == 39 || op == 47) begin
            m.fc = 6'b100000;
        end else if (op == 55 || op == 63) begin
            m.fc = 6'b100000; m.wb = 0;
        end else begin
            m.legal = 0;
        end
        return m;
    endfunction

    function automatic out_t base();
        out_t o;
        o = '0;
        o.opcode = m_op; o.prm = m_prm; o.wr_data = m_res;
        return o;
    endfunction

    function automatic out_t stall_of(input out_t e);
        out_t o;
        o = base();
        o.op_ready = e.op_ready;
        return o;
    endfunction

    // vmode: 0 quiet, 1 offer the current opcode, 2 random opcode noise
    task automatic cyc(input out_t e, input bit en, input bit ack, input int vmode);
        i_Enable   = en;
        i_Mem_Ack  = ack;
        i_Mem_Data = (ack && en) ? d_mem : 8'($urandom);
        if (vmode == 1) begin
            i_Op_Valid = 1'b1; i_CB = cur_cb; i_Op = cur_op;
        end else begin
            i_Op_Valid = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_CB = 1'($urandom_range(0, 1)); i_Op = 8'($urandom);
        end
        exp_o   = en ? e : stall_of(e);
        exp_vld = 1;
        @(posedge i_Clk); #1;
    endtask

    task automatic run_phase(input out_t e, input int vmode, input bit need_ack,
                             input int ack_after, input int n_stall);
        int en_cnt, guard;
        bit fin, en, ack;
        en_cnt = 0; guard = 0; fin = 0;
        while (!fin) begin
            if (n_stall > 0) begin
                en = 0; n_stall--;
            end else begin
                en = (stall_rnd && guard < 20) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (!need_ack) ack = 0;
            else if (!en) ack = 1'($urandom_range(0, 1));
            else ack = (en_cnt >= ack_after);
            cyc(e, en, ack, vmode);
            if (en) begin
                if (!need_ack || ack) fin = 1;
                en_cnt++;
            end
            guard++;
        end
    endtask

    task automatic run_instr(input bit cb, input logic [7:0] op, input int ack_dly,
                             input int exec_stall, input bit rst_in_mem);
        mdec_t m;
        out_t  e;
        m = model_decode(cb, int'(op));
        cur_cb = cb; cur_op = op;
        i_Reg_Data = d_reg; i_ALU_Reg_Data = d_areg; i_ALU_Result = d_res;
        e = base(); e.op_ready = 1;
        run_phase(e, 1, 0, 0, 0);
        m_op = op;
        if (!m.legal) begin
            e = base(); e.illegal = 1;
            run_phase(e, 2, 0, 0, 0);
            return;
        end
        if (m.imm || m.src == 6) begin
            e = base(); e.mem_req = 1; e.addr_sel = m.imm; e.k_mem = 1;
            if (rst_in_mem) begin
                cyc(e, 1, 0, 2);
                e = base(); e.op_ready = 1;
                i_Rst = 1;
                cyc(e, 1, 0, 0);
                i_Rst = 0;
                m_op = 8'd0; m_prm = 8'd0; m_res = 8'd0;
                return;
            end
            run_phase(e, 2, 1, (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly, 0);
            m_prm = d_mem;
        end else begin
            e = base();
            if (m.src == 7) e.alu_read = 2'b01;
            else begin e.reg_read = 1; e.reg_sel = 3'(m.src); e.k_sel = 1; end
            run_phase(e, 2, 0, 0, 0);
            m_prm = (m.src == 7) ? d_areg : d_reg;
        end
        e = base(); e.fc = m.fc; e.save = m.save; e.pc_inc = m.imm;
        run_phase(e, 2, 0, 0, exec_stall);
        m_res = d_res;
        if (m.wb && m.dst == 6) begin
            e = base(); e.mem_req = 1; e.mem_wr = 1; e.k_mem = 1; e.k_wr = 1;
            run_phase(e, 2, 1, (ack_dly < 0) ? int'($urandom_range(0, 3)) : 0, 0);
        end else begin
            e = base();
            if (m.wb) begin
                e.k_wr = 1;
                if (m.dst == 7) e.alu_write = 2'b01;
                else begin e.reg_write = 1; e.reg_sel = 3'(m.dst); e.k_sel = 1; end
            end
            run_phase(e, 2, 0, 0, 0);
        end
        e = base(); e.done = 1;
        run_phase(e, 2, 0, 0, 0);
    endtask

    task automatic idle_cycle();
        out_t e;
        e = base(); e.op_ready = 1; e.k_wr = 1;
        cyc(e, 1, 0, 0);
    endtask

    initial begin
        out_t e;
        i_Rst = 1; i_Enable = 1; i_Op_Valid = 0; i_CB = 0; i_Op = 8'd0; i_Mem_Ack = 0;
        i_Mem_Data = 8'd0; i_Reg_Data = 8'd0; i_ALU_Reg_Data = 8'd0; i_ALU_Result = 8'd0;
        d_reg = 8'd0; d_areg = 8'd0; d_mem = 8'd0; d_res = 8'd0; cur_op = 8'd0; cur_cb = 0;
        clr_cnt();
        @(posedge i_Clk); #1;
        e = base(); e.op_ready = 1; e.k_wr = 1;
        cyc(e, 1, 0, 0);
        cyc(e, 0, 0, 0);
        i_Rst = 0;
        idle_cycle();
        chk("lit_reset_ready", 8'(o_Op_Ready), 8'h01);
        chk("lit_reset_param", o_Parameter, 8'h00);
        chk("lit_reset_wrdata", o_Wr_Data, 8'h00);

        // ADD A,B
        d_reg = 8'h3C; d_areg = 8'h11; d_res = 8'h4D; d_mem = 8'h00;
        clr_cnt();
        run_instr(0, 8'h80, 0, 0, 0);
        chk("lit_add_param", o_Parameter, 8'h3C);
        chk("lit_add_opcode", o_Opcode, 8'h80);
        chk("lit_add_done", 8'(cnt_done), 8'd1);
        chk("lit_add_aluw", 8'(cnt_aluw), 8'd1);

        // CP d8 with a three-cycle ack delay
        d_mem = 8'h42; d_res = 8'h99;
        clr_cnt();
        run_instr(0, 8'hFE, 3, 0, 0);
        chk("lit_cp_req_cycles", 8'(cnt_req), 8'd4);
        chk("lit_cp_pc_inc", 8'(cnt_pc), 8'd1);
        chk("lit_cp_param", o_Parameter, 8'h42);
        chk("lit_cp_wstb", 8'(cnt_wstb), 8'd0);

        // INC (HL)
        d_mem = 8'h7F; d_res = 8'h80;
        clr_cnt();
        run_instr(0, 8'h34, 0, 0, 0);
        chk("lit_inc_memwr", 8'(cnt_memwr), 8'd1);
        chk("lit_inc_wrdata", o_Wr_Data, 8'h80);

        // CB BIT 7,H then CB SET 0,A
        d_reg = 8'h80; d_areg = 8'h00; d_res = 8'h5A;
        clr_cnt();
        run_instr(1, 8'h7C, 0, 0, 0);
        chk("lit_bit_wstb", 8'(cnt_wstb), 8'd0);
        d_res = 8'h01;
        clr_cnt();
        run_instr(1, 8'hC7, 0, 0, 0);
        chk("lit_set_aluw", 8'(cnt_aluw), 8'd1);

        // Illegal 0xD3
        clr_cnt();
        run_instr(0, 8'hD3, 0, 0, 0);
        chk("lit_illegal_pulse", 8'(cnt_ill), 8'd1);
        chk("lit_illegal_done", 8'(cnt_done), 8'd0);

        // Reset while waiting in MEM_RD on ADD A,(HL)
        run_instr(0, 8'h86, 2, 0, 1);
        chk("lit_rst_mem_req", 8'(o_Mem_Req), 8'h00);
        chk("lit_rst_opcode", o_Opcode, 8'h00);
        idle_cycle();

        // INC A with the enable dropped for three cycles in EXEC
        d_areg = 8'h0F; d_res = 8'h10;
        clr_cnt();
        run_instr(0, 8'h3C, 0, 3, 0);
        chk("lit_stall_fc_cycles", 8'(cnt_fc), 8'd1);
        chk("lit_stall_done", 8'(cnt_done), 8'd1);
        chk("lit_stall_wrdata", o_Wr_Data, 8'h10);

        stall_rnd = 1;
        for (int n = 0; n < 300; n++) begin
            d_reg = 8'($urandom); d_areg = 8'($urandom);
            d_mem = 8'($urandom); d_res = 8'($urandom);
            run_instr(($urandom_range(0, 3) == 0), 8'($urandom), -1,
                      ($urandom_range(0, 9) == 0) ? 2 : 0, 0);
        end
        stall_rnd = 0;
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
